// File: rtl/sap_pkg.sv
// ============================================================================
// Module  : sap_pkg
// Purpose : Shared types for the SAP register bank: register operation
//           encoding, bus-control decode and default bank geometry.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sap_pkg;

  // Default bank geometry
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // One operation is applied to the selected register per cycle
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  // Active-low control strobes to an operation. Load wins over inc/dec;
  // asserting inc and dec together cancels both and the bank holds.
  function automatic op_e decode_op(input logic n_load,
                                    input logic n_inc,
                                    input logic n_dec);
    op_e op;
    op = OP_HOLD;
    if (!n_load) begin
      op = OP_LOAD;
    end else if (!n_inc && n_dec) begin
      op = OP_INC;
    end else if (n_inc && !n_dec) begin
      op = OP_DEC;
    end
    return op;
  endfunction

endpackage : sap_pkg

`default_nettype wire

// File: rtl/sap_reg_cell.sv
// ============================================================================
// Module  : sap_reg_cell
// Purpose : One WIDTH-bit register of the SAP bank. Computes the value it
//           would take under the presented operation (next_o) together with
//           the wrap condition of that operation, and commits it when enabled.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sap_reg_cell
  import sap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] bus_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             wrap_d;

  // Candidate next value and wrap flag for the presented operation
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    case (op_i)
      OP_LOAD: begin
        value_d = bus_i;
      end
      OP_INC: begin
        value_d = value_q + WIDTH'(1);
        wrap_d  = &value_q;
      end
      OP_DEC: begin
        value_d = value_q - WIDTH'(1);
        wrap_d  = ~|value_q;
      end
      default: begin
        value_d = value_q;
        wrap_d  = 1'b0;
      end
    endcase
  end

  // Storage: reset clears, otherwise update only when this cell is targeted
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (en_i && (op_i != OP_HOLD)) begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign next_o  = value_d;
  assign wrap_o  = wrap_d;

endmodule : sap_reg_cell

`default_nettype wire

// File: rtl/sap_reg_bank.sv
// ============================================================================
// Module  : sap_reg_bank
// Purpose : DEPTH x WIDTH general-purpose register bank for the SAP datapath.
//           Each cycle one register (wsel) may be loaded from the bus,
//           incremented or decremented; one register (rsel) is read out with
//           zero status, and a single shared carry flag records the wrap of
//           the last inc/dec (cleared by load).
// Config  : SAP_REG_BANK_BYPASS_EN - when defined, a read of the register
//           being written shows its next value in the same cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sap_reg_bank
  import sap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             n_load,
  input  logic             n_inc,
  input  logic             n_dec,
  input  logic [AW-1:0]    wsel,
  input  logic [AW-1:0]    rsel,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             carry
);

`ifdef SAP_REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  op_e              op;
  logic             op_active;
  logic [WIDTH-1:0] cell_value [DEPTH];
  logic [WIDTH-1:0] cell_next  [DEPTH];
  logic             cell_wrap  [DEPTH];
  logic             carry_q;
  logic             carry_d;
  logic             rd_hit;

  assign op        = decode_op(n_load, n_inc, n_dec);
  assign op_active = (op != OP_HOLD);

  // One cell per register; only the cell addressed by wsel is enabled
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    sap_reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en_i    (wsel == AW'(i)),
      .op_i    (op),
      .bus_i   (bus),
      .value_o (cell_value[i]),
      .next_o  (cell_next[i]),
      .wrap_o  (cell_wrap[i])
    );
  end : g_cell

  // Shared carry: takes the wrap of the active op (a load reports no wrap)
  always_comb begin
    carry_d = carry_q;
    if (op_active) begin
      carry_d = cell_wrap[wsel];
    end
  end

  // Carry register with synchronous reset overriding the op
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  // Read port: stored contents, or the in-flight value when bypassing
  always_comb begin
    rd_hit = BYPASS && op_active && (rsel == wsel);
    value  = rd_hit ? cell_next[rsel] : cell_value[rsel];
    zero   = (value == '0);
  end

  assign carry = carry_q;

endmodule : sap_reg_bank

`default_nettype wire

// File: tb/tb_sap_reg_bank.sv
// ============================================================================
// Module  : tb_sap_reg_bank
// Purpose : Directed self-checking bench for sap_reg_bank (WIDTH=8, DEPTH=4).
// Config  : SAP_REG_BANK_BYPASS_EN selects the read-during-write expectation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sap_reg_bank;

  logic       clk;
  logic       rst;
  logic       n_load;
  logic       n_inc;
  logic       n_dec;
  logic [1:0] wsel;
  logic [1:0] rsel;
  logic [7:0] bus;
  logic [7:0] value;
  logic       zero;
  logic       carry;

  int n_cmp;
  int n_err;

  sap_reg_bank #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .n_load (n_load),
    .n_inc  (n_inc),
    .n_dec  (n_dec),
    .wsel   (wsel),
    .rsel   (rsel),
    .bus    (bus),
    .value  (value),
    .zero   (zero),
    .carry  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single clock edge, then return strobes to idle
  task automatic do_op(input logic nl, input logic ni, input logic nd,
                       input logic [1:0] ws, input logic [7:0] b);
    n_load = nl;
    n_inc  = ni;
    n_dec  = nd;
    wsel   = ws;
    bus    = b;
    @(posedge clk);
    #1;
    n_load = 1'b1;
    n_inc  = 1'b1;
    n_dec  = 1'b1;
  endtask

  task automatic rd(input logic [1:0] rs);
    rsel = rs;
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    n_load = 1'b1;
    n_inc  = 1'b1;
    n_dec  = 1'b1;
    wsel   = 2'd0;
    rsel   = 2'd0;
    bus    = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_value", value, 8'h00);
    check("rst_zero",  zero,  1'b1);
    check("rst_carry", carry, 1'b0);

    // Load reg2 = 0x5A; other registers untouched
    do_op(1'b0, 1'b1, 1'b1, 2'd2, 8'h5A);
    rd(2'd2);
    check("load_r2",      value, 8'h5A);
    check("load_r2_zero", zero,  1'b0);
    rd(2'd1);
    check("load_r1_hold", value, 8'h00);

    // Increment wrap on reg0
    do_op(1'b0, 1'b1, 1'b1, 2'd0, 8'hFF);
    do_op(1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    rd(2'd0);
    check("inc_wrap_val",   value, 8'h00);
    check("inc_wrap_carry", carry, 1'b1);
    check("inc_wrap_zero",  zero,  1'b1);
    do_op(1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    check("inc2_val",   value, 8'h01);
    check("inc2_carry", carry, 1'b0);

    // Decrement wrap on reg3, then load beats inc, then inc+dec holds
    do_op(1'b1, 1'b1, 1'b0, 2'd3, 8'h00);
    rd(2'd3);
    check("dec_wrap_val",   value, 8'hFF);
    check("dec_wrap_carry", carry, 1'b1);
    do_op(1'b0, 1'b0, 1'b1, 2'd3, 8'h10);
    check("prio_load_val",   value, 8'h10);
    check("prio_load_carry", carry, 1'b0);
    do_op(1'b1, 1'b0, 1'b0, 2'd3, 8'h77);
    check("incdec_hold_val", value, 8'h10);

    // Carry holds through inc+dec and idle cycles; non-wrapping dec clears it
    do_op(1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
    check("dec_r1_carry", carry, 1'b1);
    do_op(1'b1, 1'b0, 1'b0, 2'd3, 8'h00);
    check("incdec_carry_hold", carry, 1'b1);
    check("incdec_r3_hold",    value, 8'h10);
    do_op(1'b1, 1'b1, 1'b1, 2'd1, 8'h00);
    check("idle_carry_hold", carry, 1'b1);
    do_op(1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
    rd(2'd1);
    check("dec_nowrap_val",   value, 8'hFE);
    check("dec_nowrap_carry", carry, 1'b0);

    // Read-during-write on reg1: 0x22 stored, loading 0x33
    do_op(1'b0, 1'b1, 1'b1, 2'd1, 8'h22);
    rsel   = 2'd1;
    wsel   = 2'd1;
    bus    = 8'h33;
    n_load = 1'b0;
    #1;
`ifdef SAP_REG_BANK_BYPASS_EN
    check("rdw_same_cycle", value, 8'h33);
`else
    check("rdw_same_cycle", value, 8'h22);
`endif
    @(posedge clk);
    #1;
    n_load = 1'b1;
    check("rdw_next_cycle", value, 8'h33);

    // Reset with an inc pending on reg0 = 0x07; carry set beforehand
    do_op(1'b0, 1'b1, 1'b1, 2'd0, 8'h07);
    do_op(1'b0, 1'b1, 1'b1, 2'd2, 8'h00);
    do_op(1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
    check("pre_rst_carry", carry, 1'b1);
    rst = 1'b1;
    do_op(1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    rst = 1'b0;
    check("rst_mid_carry", carry, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rd(2'(r));
      check($sformatf("rst_mid_r%0d", r), value, 8'h00);
      check($sformatf("rst_mid_zero%0d", r), zero, 1'b1);
    end

    // Zero flag tracks rsel combinationally
    do_op(1'b0, 1'b1, 1'b1, 2'd3, 8'h80);
    rd(2'd3);
    check("zero_nonzero", zero, 1'b0);
    rd(2'd2);
    check("zero_cleared", zero, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sap_reg_bank

`default_nettype wire
